// File: rtl/mem_sched_if.sv
// Bundle of UART, engine handshake and RAM-port signals around the mem_sched arbiter.
// The master modport is the scheduler's view; slave is the surrounding system.
`timescale 1ns/1ps
interface mem_sched_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              eng_rx_ready;
  logic              act_clear;
  logic              act_capture;
  logic              act_dump;
  logic              done_clear;
  logic              done_capture;
  logic              done_dump;
  logic [ADDR_W-1:0] clr_mem_addr;
  logic [DATA_W-1:0] clr_mem_data;
  logic              clr_mem_we;
  logic [ADDR_W-1:0] cap_mem_addr;
  logic [DATA_W-1:0] cap_mem_data;
  logic              cap_mem_we;
  logic [ADDR_W-1:0] dmp_mem_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              busy;
  logic              err;
  logic              timeout;

  modport master (
    input  rx_data, rx_ready, done_clear, done_capture, done_dump,
           clr_mem_addr, clr_mem_data, clr_mem_we,
           cap_mem_addr, cap_mem_data, cap_mem_we, dmp_mem_addr,
    output eng_rx_ready, act_clear, act_capture, act_dump,
           mem_addr, mem_data, mem_we, busy, err, timeout
  );

  modport slave (
    output rx_data, rx_ready, done_clear, done_capture, done_dump,
           clr_mem_addr, clr_mem_data, clr_mem_we,
           cap_mem_addr, cap_mem_data, cap_mem_we, dmp_mem_addr,
    input  eng_rx_ready, act_clear, act_capture, act_dump,
           mem_addr, mem_data, mem_we, busy, err, timeout
  );
endinterface

// File: rtl/mem_sched.sv
// Command decoder and single-port RAM arbiter for the clear/capture/dump engines.
// Optional run watchdog enabled by defining MEM_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_sched #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter logic [7:0]  CMD_CLEAR      = 8'h43,
  parameter logic [7:0]  CMD_CAPTURE    = 8'h53,
  parameter logic [7:0]  CMD_DUMP       = 8'h52,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic         clk_50mhz,
  input  logic         reset,
  mem_sched_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_t;
  typedef enum logic [1:0] {G_NONE, G_CLR, G_CAP, G_DMP} gnt_t;

  state_t     r_state, w_state_nxt;
  gnt_t       r_gnt, w_gnt_nxt;
  logic [2:0] r_act, w_act_nxt;   // {dump, capture, clear}
  logic       r_err, w_err_nxt;
  logic       r_busy;
  logic       w_done;
  logic       w_expire;

  // Done of the engine currently holding the grant; others are ignored.
  always_comb begin
    w_done = 1'b0;
    case (r_gnt)
      G_CLR:   w_done = bus.done_clear;
      G_CAP:   w_done = bus.done_capture;
      G_DMP:   w_done = bus.done_dump;
      default: w_done = 1'b0;
    endcase
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Counter sits at zero outside RUN, so it starts from zero on every entry.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (r_state == S_RUN) ? r_cnt + CNT_W'(1) : '0;
      r_timeout <= (r_state == S_RUN) && w_expire && !w_done;
    end
  end

  assign w_expire    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout = r_timeout;
`else
  assign w_expire    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= G_NONE;
      r_act   <= 3'b000;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_act   <= w_act_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_act_nxt   = r_act;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == CMD_CLEAR) begin
            w_gnt_nxt   = G_CLR;
            w_act_nxt   = 3'b001;
            w_state_nxt = S_RUN;
          end else if (bus.rx_data == CMD_CAPTURE) begin
            w_gnt_nxt   = G_CAP;
            w_act_nxt   = 3'b010;
            w_state_nxt = S_RUN;
          end else if (bus.rx_data == CMD_DUMP) begin
            w_gnt_nxt   = G_DMP;
            w_act_nxt   = 3'b100;
            w_state_nxt = S_RUN;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (w_done || w_expire) begin
          w_act_nxt   = 3'b000;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_act_nxt = 3'b000;
        w_err_nxt = bus.rx_ready;
        if (!w_done) begin
          w_gnt_nxt   = G_NONE;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = G_NONE;
        w_act_nxt   = 3'b000;
      end
    endcase
  end

  // Zero-latency RAM port mux; the dump engine only reads.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_we   = 1'b0;
    case (r_gnt)
      G_CLR: begin
        bus.mem_addr = bus.clr_mem_addr;
        bus.mem_data = bus.clr_mem_data;
        bus.mem_we   = bus.clr_mem_we;
      end
      G_CAP: begin
        bus.mem_addr = bus.cap_mem_addr;
        bus.mem_data = bus.cap_mem_data;
        bus.mem_we   = bus.cap_mem_we;
      end
      G_DMP:   bus.mem_addr = bus.dmp_mem_addr;
      default: bus.mem_addr = '0;
    endcase
  end

  assign bus.eng_rx_ready = bus.rx_ready && (r_state == S_RUN);
  assign bus.act_clear    = r_act[0];
  assign bus.act_capture  = r_act[1];
  assign bus.act_dump     = r_act[2];
  assign bus.busy         = r_busy;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: random command traffic against a command-level model.
`timescale 1ns/1ps
module tb_mem_sched;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 50_000_000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] cmds [3] = '{8'h43, 8'h53, 8'h52};

  mem_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_50mhz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  // Model: which engine a byte activates, as {dump, capture, clear}.
  function automatic logic [2:0] exp_act(input logic [7:0] b);
    if (b == 8'h43) return 3'b001;
    if (b == 8'h53) return 3'b010;
    if (b == 8'h52) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] get_act();
    return {bus.act_dump, bus.act_capture, bus.act_clear};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_data = 8'h00;  bus.rx_ready = 1'b0;
    bus.done_clear = 1'b0; bus.done_capture = 1'b0; bus.done_dump = 1'b0;
    bus.clr_mem_addr = '0; bus.clr_mem_data = '0; bus.clr_mem_we = 1'b0;
    bus.cap_mem_addr = '0; bus.cap_mem_data = '0; bus.cap_mem_we = 1'b0;
    bus.dmp_mem_addr = '0;
  endtask

  task automatic set_done(input logic [2:0] d);
    bus.done_clear = d[0]; bus.done_capture = d[1]; bus.done_dump = d[2];
  endtask

  // Presents one byte for one edge; reports eng_rx_ready seen while it was presented.
  task automatic send_byte(input logic [7:0] b, output logic fwd);
    bus.rx_data = b; bus.rx_ready = 1'b1;
    #1;
    fwd = bus.eng_rx_ready;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  // Raises then drops the engine's done; returns act after the rise and busy at each step.
  task automatic finish_engine(input logic [2:0] eng, output logic [2:0] a_rel,
                               output logic b_rel, output logic b_idle);
    set_done(eng);
    tick();
    a_rel = get_act(); b_rel = bus.busy;
    set_done(3'b000);
    tick();
    b_idle = bus.busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.cap_mem_we = 1'b1;
    bus.cap_mem_addr = 8'h5A;
    #15;
    n_checks++;
    if ({get_act(), bus.busy, bus.err, bus.timeout, bus.mem_we} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000000",
                         {get_act(), bus.busy, bus.err, bus.timeout, bus.mem_we});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_data} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mux: got %h expected 0000", {bus.mem_addr, bus.mem_data});
    end
    #25 reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_clear();
    logic fwd; logic [2:0] a; logic br, bi; int fwd_cnt;
    send_byte(8'h43, fwd);
    n_checks++;
    if (fwd !== 1'b0) begin n_fail++; $display("FAIL clear_cmd_fwd: got %b expected 0", fwd); end
    n_checks++;
    if ({get_act(), bus.busy} !== {exp_act(8'h43), 1'b1}) begin
      n_fail++; $display("FAIL clear_act: got %b expected %b", {get_act(), bus.busy}, {exp_act(8'h43), 1'b1});
    end
    fwd_cnt = 0;
    send_byte(8'hA5, fwd);
    if (fwd) fwd_cnt++;
    for (int i = 0; i < 256; i++) begin
      bus.clr_mem_addr = 8'(i); bus.clr_mem_data = 8'hA5; bus.clr_mem_we = 1'b1;
      bus.cap_mem_addr = 8'($urandom); bus.cap_mem_data = 8'($urandom);
      bus.cap_mem_we = 1'($urandom); bus.dmp_mem_addr = 8'($urandom);
      #1;
      if (bus.eng_rx_ready) fwd_cnt++;
      n_checks++;
      if ({bus.mem_addr, bus.mem_data, bus.mem_we} !== {8'(i), 8'hA5, 1'b1}) begin
        n_fail++; $display("FAIL clear_mux addr %0d: got %h expected %h", i,
                           {bus.mem_addr, bus.mem_data, bus.mem_we}, {8'(i), 8'hA5, 1'b1});
      end
      tick();
    end
    bus.clr_mem_we = 1'b0;
    n_checks++;
    if (fwd_cnt !== 1) begin n_fail++; $display("FAIL clear_fwd_count: got %0d expected 1", fwd_cnt); end
    finish_engine(3'b001, a, br, bi);
    n_checks++;
    if ({a, br, bi} !== 5'b000_1_0) begin
      n_fail++; $display("FAIL clear_done: got %b expected 00010", {a, br, bi});
    end
  endtask

  task automatic test_unknown();
    logic fwd; logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      do b = 8'($urandom); while (exp_act(b) != 3'b000);
      send_byte(b, fwd);
      n_checks++;
      if ({fwd, bus.err, get_act(), bus.busy, bus.mem_we} !== 7'b0_1_000_0_0) begin
        n_fail++; $display("FAIL unknown_%h: got %b expected 0100000", b,
                           {fwd, bus.err, get_act(), bus.busy, bus.mem_we});
      end
      tick();
      n_checks++;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL unknown_err_len: got %b expected 0", bus.err); end
    end
  endtask

  task automatic test_grant_isolation();
    logic fwd; logic [2:0] a; logic br, bi; logic [7:0] ad, da; logic we;
    send_byte(8'h53, fwd);
    bus.clr_mem_we = 1'b1; bus.clr_mem_addr = 8'h10; bus.clr_mem_data = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      ad = 8'($urandom); da = 8'($urandom); we = 1'($urandom);
      bus.cap_mem_addr = ad; bus.cap_mem_data = da; bus.cap_mem_we = we;
      bus.dmp_mem_addr = 8'($urandom);
      bus.done_dump = (k >= 2);
      bus.done_clear = (k >= 4);
      #1;
      n_checks++;
      if ({bus.mem_addr, bus.mem_data, bus.mem_we} !== {ad, da, we}) begin
        n_fail++; $display("FAIL iso_mux: got %h expected %h", {bus.mem_addr, bus.mem_data, bus.mem_we}, {ad, da, we});
      end
      tick();
    end
    n_checks++;
    if ({get_act(), bus.busy} !== 4'b010_1) begin
      n_fail++; $display("FAIL iso_ignore_done: got %b expected 0101", {get_act(), bus.busy});
    end
    set_done(3'b000);
    send_byte(8'h43, fwd);
    n_checks++;
    if ({fwd, get_act(), bus.err} !== 5'b1_010_0) begin
      n_fail++; $display("FAIL iso_run_byte: got %b expected 10100", {fwd, get_act(), bus.err});
    end
    bus.clr_mem_we = 1'b0; bus.cap_mem_we = 1'b0;
    finish_engine(3'b010, a, br, bi);
    n_checks++;
    if ({a, br, bi} !== 5'b000_1_0) begin
      n_fail++; $display("FAIL iso_done: got %b expected 00010", {a, br, bi});
    end
  endtask

  task automatic test_release_byte();
    logic fwd; logic [7:0] c; logic [2:0] a; logic br, bi;
    c = cmds[$urandom_range(2, 0)];
    send_byte(c, fwd);
    set_done(exp_act(c));
    tick();
    send_byte(8'($urandom), fwd);
    n_checks++;
    if ({fwd, bus.err, get_act(), bus.busy} !== 6'b0_1_000_1) begin
      n_fail++; $display("FAIL release_byte: got %b expected 010001", {fwd, bus.err, get_act(), bus.busy});
    end
    tick();
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL release_err_len: got %b expected 0", bus.err); end
    set_done(3'b000);
    tick();
    send_byte(8'h52, fwd);
    n_checks++;
    if ({get_act(), bus.busy} !== 4'b100_1) begin
      n_fail++; $display("FAIL release_next_cmd: got %b expected 1001", {get_act(), bus.busy});
    end
    finish_engine(3'b100, a, br, bi);
  endtask

  task automatic test_reset_mid_run();
    logic fwd; logic [7:0] ad; logic [2:0] a; logic br, bi;
    send_byte(8'h53, fwd);
    ad = 8'($urandom);
    bus.cap_mem_we = 1'b1; bus.cap_mem_addr = ad;
    #1;
    n_checks++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b1, ad}) begin
      n_fail++; $display("FAIL rst_pre: got %h expected %h", {bus.mem_we, bus.mem_addr}, {1'b1, ad});
    end
    #4 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_we, get_act(), bus.busy} !== 5'b0) begin
      n_fail++; $display("FAIL rst_async: got %b expected 00000", {bus.mem_we, get_act(), bus.busy});
    end
    #3 reset = 1'b0;
    bus.cap_mem_we = 1'b0;
    tick();
    send_byte(8'h52, fwd);
    n_checks++;
    if ({get_act(), bus.busy} !== 4'b100_1) begin
      n_fail++; $display("FAIL rst_then_dump: got %b expected 1001", {get_act(), bus.busy});
    end
    finish_engine(3'b100, a, br, bi);
  endtask

  task automatic test_back_to_back();
    logic fwd; logic [7:0] c; logic [2:0] a; logic br, bi; int run_len;
    for (int k = 0; k < 6; k++) begin
      c = cmds[$urandom_range(2, 0)];
      send_byte(c, fwd);
      n_checks++;
      if ({fwd, get_act(), bus.busy} !== {1'b0, exp_act(c), 1'b1}) begin
        n_fail++; $display("FAIL b2b_start_%h: got %b expected %b", c, {fwd, get_act(), bus.busy}, {1'b0, exp_act(c), 1'b1});
      end
      run_len = $urandom_range(4, 1);
      for (int j = 0; j < run_len; j++) begin
        send_byte(8'($urandom), fwd);
        n_checks++;
        if ({fwd, get_act()} !== {1'b1, exp_act(c)}) begin
          n_fail++; $display("FAIL b2b_run_fwd: got %b expected %b", {fwd, get_act()}, {1'b1, exp_act(c)});
        end
      end
      finish_engine(exp_act(c), a, br, bi);
      n_checks++;
      if ({a, br, bi} !== 5'b000_1_0) begin
        n_fail++; $display("FAIL b2b_done: got %b expected 00010", {a, br, bi});
      end
    end
  endtask

`ifdef MEM_SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    logic fwd; int early;
    send_byte(8'h52, fwd);
    early = 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (get_act() !== 3'b100 || bus.timeout !== 1'b0) early++;
    end
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL wd_early: got %0d bad cycles expected 0", early); end
    tick();
    n_checks++;
    if ({get_act(), bus.timeout, bus.busy} !== 5'b000_1_1) begin
      n_fail++; $display("FAIL wd_fire: got %b expected 00011", {get_act(), bus.timeout, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.timeout, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL wd_idle: got %b expected 00", {bus.timeout, bus.busy});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MEM_SCHED_TIMEOUT_EN
    test_unknown();
    test_watchdog();
`else
    test_clear();
    test_unknown();
    test_grant_isolation();
    test_release_byte();
    test_reset_mid_run();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
